// File: rtl/uart_periph_pkg.sv
// Shared definitions for the UART peripheral: register offsets, CON bit layout,
// FSM state encoding and the baud divisor helper.
package uart_periph_pkg;

  localparam logic [31:0] OFF_TXD = 32'h0;
  localparam logic [31:0] OFF_RXD = 32'h4;
  localparam logic [31:0] OFF_CON = 32'h8;

  localparam int CON_TX_IRQ_EN = 0;
  localparam int CON_RX_IRQ_EN = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_READY  = 3;
  localparam int CON_TX_BUSY   = 4;
  localparam int CON_OVERRUN   = 5;
  localparam int CON_W         = 6;

  // 16 ticks per bit; the receiver centres its samples 8 ticks into the start bit.
  localparam logic [3:0] TICKS_LAST = 4'd15;
  localparam logic [3:0] TICKS_MID  = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int baud_div(input int clk_freq, input int baud);
    int d;
    d = clk_freq / (baud * 16);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_periph_if.sv
// MEM-stage data bus as seen by the UART peripheral.
interface uart_periph_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        sel;

  modport master (output rd, output wr, output addr, output wdata, input rdata, input sel);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata, output sel);
endinterface

// File: rtl/uart_periph_baud_gen.sv
// Free-running 16x oversampling tick: one-cycle pulse every DIV clocks.
module uart_baud_gen
  import uart_periph_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            DIV  = baud_div(CLK_FREQ, BAUD);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      tick_q <= 1'b0;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers, TX and RX FSMs, interrupt output.
// State advances on the falling clock edge, in step with the data-memory writes.
module uart_periph
  import uart_periph_pkg::*;
#(
  parameter int          CLK_FREQ  = 50_000_000,
  parameter int          BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
  input  logic         clk,
  input  logic         reset,
  uart_periph_if.slave bus,
  input  logic         uart_rx,
  output logic         uart_tx,
  output logic         irqout
);

  logic tick;

  uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_baud (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  logic hit_txd, hit_rxd, hit_con;
  logic wr_txd, wr_con, rd_rxd, rd_con;

  assign hit_txd = (bus.addr == BASE_ADDR + OFF_TXD);
  assign hit_rxd = (bus.addr == BASE_ADDR + OFF_RXD);
  assign hit_con = (bus.addr == BASE_ADDR + OFF_CON);
  assign wr_txd  = bus.wr & hit_txd;
  assign wr_con  = bus.wr & hit_con;
  assign rd_rxd  = bus.rd & hit_rxd;
  assign rd_con  = bus.rd & hit_con;
  assign bus.sel = bus.rd & (hit_txd | hit_rxd | hit_con);

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:8];

  uart_state_e tx_state_q, rx_state_q;
  logic [7:0]  tx_shift_q, rx_shift_q;
  logic [3:0]  tx_tick_q, rx_tick_q;
  logic [2:0]  tx_bit_q, rx_bit_q;
  logic        uart_tx_q;
  logic        rx_s1_q, rx_s2_q;

  logic [7:0]  rxd_q, rxd_d;
  logic        tx_irq_en_q, tx_irq_en_d;
  logic        rx_irq_en_q, rx_irq_en_d;
  logic        tx_done_q, tx_done_d;
  logic        rx_ready_q, rx_ready_d;
  logic        overrun_q, overrun_d;
  logic [CON_W-1:0] con;

  logic tx_finish, rx_commit;

  assign tx_finish = (tx_state_q == ST_STOP) && tick && (tx_tick_q == TICKS_LAST);
  assign rx_commit = (rx_state_q == ST_STOP) && tick && (rx_tick_q == TICKS_LAST) && rx_s2_q;

  // Transmitter: TXD writes are only accepted while idle, so an in-flight frame is never disturbed.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= ST_IDLE;
      tx_shift_q <= '0;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      uart_tx_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        ST_IDLE: begin
          if (wr_txd) begin
            tx_shift_q <= bus.wdata[7:0];
            tx_tick_q  <= '0;
            uart_tx_q  <= 1'b0;
            tx_state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == TICKS_LAST) begin
              tx_bit_q   <= '0;
              uart_tx_q  <= tx_shift_q[0];
              tx_state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == TICKS_LAST) begin
              if (tx_bit_q == 3'd7) begin
                uart_tx_q  <= 1'b1;
                tx_state_q <= ST_STOP;
              end else begin
                tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                uart_tx_q  <= tx_shift_q[1];
                tx_bit_q   <= tx_bit_q + 3'd1;
              end
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_tick_q == TICKS_LAST) tx_state_q <= ST_IDLE;
          end
        end
        default: tx_state_q <= ST_IDLE;
      endcase
    end
  end

  // Receiver: synchronised input, start bit re-checked at mid-bit to reject glitches.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_shift_q <= '0;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
      case (rx_state_q)
        ST_IDLE: begin
          if (!rx_s2_q) begin
            rx_tick_q  <= '0;
            rx_state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            if (rx_tick_q == TICKS_MID) begin
              rx_tick_q  <= '0;
              rx_bit_q   <= '0;
              rx_state_q <= rx_s2_q ? ST_IDLE : ST_DATA;
            end else begin
              rx_tick_q <= rx_tick_q + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            rx_tick_q <= rx_tick_q + 4'd1;
            if (rx_tick_q == TICKS_LAST) begin
              rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
              if (rx_bit_q == 3'd7) rx_state_q <= ST_STOP;
              else                  rx_bit_q   <= rx_bit_q + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            rx_tick_q <= rx_tick_q + 4'd1;
            if (rx_tick_q == TICKS_LAST) rx_state_q <= ST_IDLE;
          end
        end
        default: rx_state_q <= ST_IDLE;
      endcase
    end
  end

  // Flag updates: a completing frame outranks a clearing read in the same cycle.
  always_comb begin
    tx_irq_en_d = tx_irq_en_q;
    rx_irq_en_d = rx_irq_en_q;
    tx_done_d   = tx_done_q;
    rx_ready_d  = rx_ready_q;
    overrun_d   = overrun_q;
    rxd_d       = rxd_q;
    if (wr_con) begin
      tx_irq_en_d = bus.wdata[CON_TX_IRQ_EN];
      rx_irq_en_d = bus.wdata[CON_RX_IRQ_EN];
    end
    if (rd_con) begin
      tx_done_d  = 1'b0;
      rx_ready_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (rd_rxd) rx_ready_d = 1'b0;
    if (tx_finish) tx_done_d = 1'b1;
    if (rx_commit) begin
      rxd_d      = rx_shift_q;
      rx_ready_d = 1'b1;
      if (rx_ready_q) overrun_d = 1'b1;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      tx_irq_en_q <= 1'b0;
      rx_irq_en_q <= 1'b0;
      tx_done_q   <= 1'b0;
      rx_ready_q  <= 1'b0;
      overrun_q   <= 1'b0;
      rxd_q       <= '0;
    end else begin
      tx_irq_en_q <= tx_irq_en_d;
      rx_irq_en_q <= rx_irq_en_d;
      tx_done_q   <= tx_done_d;
      rx_ready_q  <= rx_ready_d;
      overrun_q   <= overrun_d;
      rxd_q       <= rxd_d;
    end
  end

  always_comb begin
    con                = '0;
    con[CON_TX_IRQ_EN] = tx_irq_en_q;
    con[CON_RX_IRQ_EN] = rx_irq_en_q;
    con[CON_TX_DONE]   = tx_done_q;
    con[CON_RX_READY]  = rx_ready_q;
    con[CON_TX_BUSY]   = (tx_state_q != ST_IDLE);
    con[CON_OVERRUN]   = overrun_q;
  end

  always_comb begin
    bus.rdata = '0;
    if (rd_rxd)      bus.rdata = {24'b0, rxd_q};
    else if (rd_con) bus.rdata = {26'b0, con};
  end

  assign uart_tx = uart_tx_q;
  assign irqout  = (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_ready_q);

endmodule
